// File: rtl/rom_loader.sv
//------------------------------------------------------------------------------
// rom_loader
//   Buffers ioctl ROM-download bytes and commits them as bank/page mapped SDRAM
//   writes in reference slots, holding the system in reset until done.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rom_loader #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ce_ref,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [1:0]  mem_bank,
    output logic [7:0]  mem_din,
    output logic        hold_reset,
    output logic        done,
    output logic        overflow,
    output logic [15:0] dropped
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam int EW = 33;
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_TAIL  = 2'd3;

    logic [1:0]    state, state_nx;
    logic [CW-1:0] hold_cnt;
    logic          cnt_load;
    logic          dl_prev;
    logic          dl0, dl_rise, dl_fall, accept;

    logic [10:0]   seg;
    logic          in_map;
    logic [8:0]    page;
    logic [22:0]   map_addr;
    logic [1:0]    map_bank;

    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [EW-1:0] head;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          empty, full, pop, push, lost;

    logic [22:0]   last_addr;
    logic [1:0]    last_bank;
    logic [7:0]    last_din;

    // Edges are tracked on the index-0 download only, so other targets never move the FSM.
    assign dl0     = ioctl_download & (ioctl_index == 8'd0);
    assign dl_rise = dl0 & ~dl_prev;
    assign dl_fall = ~dl0 & dl_prev;
    assign accept  = dl0 & ioctl_wr;

    assign seg    = ioctl_addr[24:14];
    assign in_map = (seg[10:3] == 8'd0);

    always_comb begin
        page = 9'h000;
        case (seg[1:0])
            2'd0: page = 9'h000;
            2'd1: page = 9'h100;
            2'd2: page = 9'h107;
            2'd3: page = 9'h1ff;
            default: page = 9'h000;
        endcase
    end

    assign map_addr = {page, ioctl_addr[13:0]};
    assign map_bank = {1'b0, seg[2]};

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign pop   = ce_ref & ~empty;
    assign push  = accept & in_map & (~full | pop);
    assign lost  = accept & in_map & full & ~pop;
    assign head  = fifo_mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (push)
            fifo_mem[wr_ptr] <= {map_addr, map_bank, ioctl_dout};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            last_addr <= '0;
            last_bank <= '0;
            last_din  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_addr <= head[32:10];
                last_bank <= head[9:8];
                last_din  <= head[7:0];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign mem_we   = pop;
    assign mem_addr = pop ? head[32:10] : last_addr;
    assign mem_bank = pop ? head[9:8]   : last_bank;
    assign mem_din  = pop ? head[7:0]   : last_din;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            dropped  <= '0;
            dl_prev  <= 1'b0;
        end else begin
            dl_prev <= dl0;
            if (state == S_IDLE && dl_rise)
                overflow <= 1'b0;
            if (lost)
                overflow <= 1'b1;
            if (accept && !in_map && dropped != 16'hFFFF)
                dropped <= dropped + 16'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
        end else begin
            state <= state_nx;
            if (cnt_load)
                hold_cnt <= HOLD_INIT;
            else if (state == S_TAIL && hold_cnt != '0)
                hold_cnt <= hold_cnt - 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (dl_rise) state_nx = S_LOAD;
            S_LOAD:  if (dl_fall) state_nx = S_DRAIN;
            S_DRAIN: begin
                if (dl_rise)             state_nx = S_LOAD;
                else if (empty && !pop)  state_nx = S_TAIL;
            end
            S_TAIL: begin
                if (dl_rise)              state_nx = S_LOAD;
                else if (hold_cnt == '0)  state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        hold_reset = (state != S_IDLE);
        done       = (state == S_TAIL) && (state_nx == S_IDLE);
        cnt_load   = (state == S_DRAIN) && (state_nx == S_TAIL);
    end

endmodule

`default_nettype wire

// File: tb/tb_rom_loader.sv
//------------------------------------------------------------------------------
// tb_rom_loader
//   Self-checking bench: mapping vector table, corner sequences and randomized
//   traffic checked against a queue-based reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_rom_loader;

    localparam int DEPTH = 4;
    localparam int HOLD  = 16;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ce_ref = 1'b0;
    logic        mem_we;
    logic [22:0] mem_addr;
    logic [1:0]  mem_bank;
    logic [7:0]  mem_din;
    logic        hold_reset;
    logic        done;
    logic        overflow;
    logic [15:0] dropped;

    rom_loader #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ce_ref(ce_ref), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_bank(mem_bank), .mem_din(mem_din), .hold_reset(hold_reset),
        .done(done), .overflow(overflow), .dropped(dropped)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [22:0] a;
        logic [1:0]  b;
        logic [7:0]  d;
    } ent_t;

    typedef struct {
        logic [24:0] a;
        logic [7:0]  d;
        bit          valid;
        logic [22:0] ea;
        logic [1:0]  eb;
    } vec_t;

    ent_t mq[$];
    bit   ovf_m;
    int   drop_m;
    int   checks;
    int   failures;
    int   cyc;

    logic        obs_we, obs_hold, obs_done, obs_ovf;
    logic [22:0] obs_addr;
    logic [1:0]  obs_bank;
    logic [7:0]  obs_din;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void ref_map(input logic [24:0] a, output bit ok,
                                    output logic [22:0] ma, output logic [1:0] mb);
        logic [8:0] pages [4];
        int seg;
        pages[0] = 9'h000; pages[1] = 9'h100; pages[2] = 9'h107; pages[3] = 9'h1ff;
        seg = int'(a) / 16384;
        ok  = (seg < 8);
        ma  = {pages[seg % 4], a[13:0]};
        mb  = (seg >= 4) ? 2'd1 : 2'd0;
    endfunction

    // One clk_sys cycle: drive, sample at the falling edge, compare, advance model.
    task automatic step(input logic dl, input logic [7:0] idx, input logic wr,
                        input logic [24:0] a, input logic [7:0] d, input logic ce);
        bit pop, ok;
        ent_t e;
        logic [22:0] ma;
        logic [1:0]  mb;
        @(posedge clk_sys); #1;
        ioctl_download = dl; ioctl_index = idx; ioctl_wr = wr;
        ioctl_addr = a; ioctl_dout = d; ce_ref = ce;
        @(negedge clk_sys);
        obs_we = mem_we; obs_addr = mem_addr; obs_bank = mem_bank; obs_din = mem_din;
        obs_hold = hold_reset; obs_done = done; obs_ovf = overflow;
        pop = ce && (mq.size() > 0);
        check("mem_we", obs_we, pop);
        if (pop) begin
            e = mq[0];
            check("mem_addr", obs_addr, e.a);
            check("mem_bank", obs_bank, e.b);
            check("mem_din",  obs_din,  e.d);
        end
        check("overflow", obs_ovf, ovf_m);
        check("dropped",  dropped, drop_m);
        if (pop) void'(mq.pop_front());
        if (dl && idx == 8'd0 && wr) begin
            ref_map(a, ok, ma, mb);
            if (!ok) begin
                if (drop_m < 65535) drop_m++;
            end else if (mq.size() < DEPTH) begin
                mq.push_back(ent_t'({ma, mb, d}));
            end else begin
                ovf_m = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic start_dl();
        step(1'b1, 8'd0, 1'b0, '0, '0, 1'b0);
        ovf_m = 1'b0;
    endtask

    task automatic end_dl();
        step(1'b0, 8'd0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wait_done(input int budget, input int period, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step(1'b0, 8'd0, 1'b0, '0, '0, (cyc % period) == 0);
            if (obs_done) begin
                found = 1'b1;
                check({name, "_done_hold"}, obs_hold, 1);
            end
        end
        check({name, "_done_seen"}, found, 1);
        if (found) begin
            step(1'b0, 8'd0, 1'b0, '0, '0, 1'b0);
            check({name, "_done_pulse"}, obs_done, 0);
            check({name, "_idle_hold"}, obs_hold, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs [12];
        int we_cnt, we_cyc, done_cyc;
        bit found;

        vecs[0]  = '{25'h0000000, 8'h11, 1'b1, 23'h000000, 2'd0};
        vecs[1]  = '{25'h0004000, 8'h22, 1'b1, 23'h400000, 2'd0};
        vecs[2]  = '{25'h0008000, 8'h33, 1'b1, 23'h41C000, 2'd0};
        vecs[3]  = '{25'h000C000, 8'h44, 1'b1, 23'h7FC000, 2'd0};
        vecs[4]  = '{25'h0010000, 8'h55, 1'b1, 23'h000000, 2'd1};
        vecs[5]  = '{25'h001C000, 8'h66, 1'b1, 23'h7FC000, 2'd1};
        vecs[6]  = '{25'h0004001, 8'hA5, 1'b1, 23'h400001, 2'd0};
        vecs[7]  = '{25'h001FFFF, 8'h77, 1'b1, 23'h7FFFFF, 2'd1};
        vecs[8]  = '{25'h001A5A5, 8'h88, 1'b1, 23'h41E5A5, 2'd1};
        vecs[9]  = '{25'h0014321, 8'h99, 1'b1, 23'h400321, 2'd1};
        vecs[10] = '{25'h0020000, 8'hBB, 1'b0, 23'h000000, 2'd0};
        vecs[11] = '{25'h003FFFF, 8'hCC, 1'b0, 23'h000000, 2'd0};

        checks = 0; failures = 0; cyc = 0; ovf_m = 1'b0; drop_m = 0;

        // Reset state, with a reference slot active to make sure nothing writes.
        ce_ref = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_bank", mem_bank, 0);
        check("rst_mem_din", mem_din, 0);
        check("rst_hold", hold_reset, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_dropped", dropped, 0);
        ce_ref = 1'b0;
        reset_n = 1'b1;

        // Mapping table: one byte at a time, popped in the next reference slot.
        start_dl();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'd0, 1'b1, vecs[i].a, vecs[i].d, 1'b0);
            step(1'b1, 8'd0, 1'b0, '0, '0, 1'b1);
            check("map_we", obs_we, vecs[i].valid);
            if (vecs[i].valid) begin
                check("map_addr", obs_addr, vecs[i].ea);
                check("map_bank", obs_bank, vecs[i].eb);
                check("map_din", obs_din, vecs[i].d);
            end
        end
        check("map_dropped", dropped, 2);
        check("map_overflow", obs_ovf, 0);
        end_dl();
        wait_done(100, 1, "map");

        // Single byte with sparse reference slots and done timing.
        start_dl();
        step(1'b1, 8'd0, 1'b1, 25'h0004001, 8'hA5, 1'b0);
        end_dl();
        check("single_hold", obs_hold, 1);
        we_cnt = 0; we_cyc = 0; done_cyc = 0; found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1'b0, 8'd0, 1'b0, '0, '0, (cyc % 16) == 0);
            if (obs_we) begin
                we_cnt++;
                we_cyc = cyc;
                check("single_addr", obs_addr, 23'h400001);
                check("single_bank", obs_bank, 0);
                check("single_din", obs_din, 8'hA5);
            end
            if (obs_done) begin
                found = 1'b1;
                done_cyc = cyc;
            end
        end
        check("single_done_seen", found, 1);
        check("single_we_count", we_cnt, 1);
        check("single_done_delay", done_cyc - we_cyc, HOLD + 1);
        step(1'b0, 8'd0, 1'b0, '0, '0, 1'b0);
        check("single_idle_hold", obs_hold, 0);

        // Overflow: five bytes into a four-entry FIFO with no reference slots.
        start_dl();
        for (int i = 0; i < 5; i++)
            step(1'b1, 8'd0, 1'b1, 25'(32'h100 * i), 8'(8'h10 + i), 1'b0);
        step(1'b1, 8'd0, 1'b0, '0, '0, 1'b0);
        check("ovf_set", obs_ovf, 1);
        we_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'd0, 1'b0, '0, '0, 1'b1);
            if (obs_we) we_cnt++;
        end
        check("ovf_we_count", we_cnt, 4);
        end_dl();
        wait_done(100, 1, "ovf");

        // Full FIFO with push and pop in the same cycle.
        start_dl();
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'd0, 1'b1, 25'(32'h8000 + i), 8'(8'h60 + i), 1'b0);
        step(1'b1, 8'd0, 1'b1, 25'h0010007, 8'h6F, 1'b1);
        check("simul_pop", obs_we, 1);
        step(1'b1, 8'd0, 1'b0, '0, '0, 1'b0);
        check("simul_ovf", obs_ovf, 0);
        we_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'd0, 1'b0, '0, '0, 1'b1);
            if (obs_we) we_cnt++;
        end
        check("simul_we_count", we_cnt, 4);
        end_dl();
        wait_done(100, 1, "simul");

        // Non-zero index download: ignored entirely.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h03, 1'b1, 25'(32'h40 * i), 8'hE0, 1'b1);
            check("idx_hold", obs_hold, 0);
        end
        step(1'b0, 8'h03, 1'b0, '0, '0, 1'b0);
        check("idx_hold_end", obs_hold, 0);

        // Randomized traffic against the queue model.
        start_dl();
        for (int i = 0; i < 400; i++)
            step(1'b1, 8'd0, 1'($urandom_range(0, 1)), 25'($urandom_range(0, 32'h27FFF)),
                 8'($urandom), ($urandom_range(0, 3) == 0));
        end_dl();
        wait_done(300, 3, "rand");

        // Asynchronous reset in DRAIN with three bytes queued.
        start_dl();
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'd0, 1'b1, 25'(32'h4000 + i), 8'(8'hC0 + i), 1'b0);
        end_dl();
        step(1'b0, 8'd0, 1'b0, '0, '0, 1'b0);
        check("drain_hold", obs_hold, 1);
        @(posedge clk_sys); #2;
        reset_n = 1'b0;
        ce_ref  = 1'b1;
        #1;
        check("arst_hold", hold_reset, 0);
        check("arst_we", mem_we, 0);
        check("arst_dropped", dropped, 0);
        mq.delete();
        ovf_m = 1'b0;
        drop_m = 0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        ce_ref  = 1'b0;
        we_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'd0, 1'b0, '0, '0, 1'b1);
            if (obs_we) we_cnt++;
        end
        check("arst_no_we", we_cnt, 0);
        start_dl();
        step(1'b1, 8'd0, 1'b1, 25'h001C123, 8'h3C, 1'b0);
        end_dl();
        wait_done(100, 2, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
